// File: rtl/custom_axi_ip_pkg.sv
// rtl/custom_axi_ip_pkg.sv - shared types and register map for the custom_axi_ip front-end
package custom_axi_ip_pkg;

   // Core state as reported on status_i
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } status_e;

   // Register word indices (byte address bits [3:2])
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_DIN    = 2'd1;
   localparam logic [1:0] REG_RESULT = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   // CTRL bit positions
   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_CLR_BIT   = 1;

   // STATUS bit positions
   localparam int STATUS_BUSY_BIT    = 0;
   localparam int STATUS_DONE_BIT    = 1;
   localparam int STATUS_TIMEOUT_BIT = 2;
   localparam int STATUS_CORE_LSB    = 4;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_RUN   = 2'd1,
      SEQ_DRAIN = 2'd2
   } seq_state_e;

   // RESULT and STATUS are read-only; writes to them are rejected
   function automatic logic is_ro_reg(input logic [1:0] idx);
      return (idx == REG_RESULT) || (idx == REG_STATUS);
   endfunction

endpackage

// File: rtl/custom_axi_ip_regs_if.sv
// rtl/custom_axi_ip_regs_if.sv - AXI4-Lite slave bus bundle for the register front-end
interface custom_axi_ip_regs_if
   import custom_axi_ip_pkg::*;
#(
   parameter int ADDR_WIDTH = 4
) ();
   logic [ADDR_WIDTH-1:0] s_awaddr;
   logic                  s_awvalid;
   logic                  s_awready;
   logic [31:0]           s_wdata;
   logic [3:0]            s_wstrb;
   logic                  s_wvalid;
   logic                  s_wready;
   axi_resp_e             s_bresp;
   logic                  s_bvalid;
   logic                  s_bready;
   logic [ADDR_WIDTH-1:0] s_araddr;
   logic                  s_arvalid;
   logic                  s_arready;
   logic [31:0]           s_rdata;
   axi_resp_e             s_rresp;
   logic                  s_rvalid;
   logic                  s_rready;

   modport master (
      output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready,
      input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata,
             s_rresp, s_rvalid
   );

   modport slave (
      input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready,
      output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata,
             s_rresp, s_rvalid
   );
endinterface

// File: rtl/custom_axi_ip_seq.sv
// rtl/custom_axi_ip_seq.sv - run sequencer: holds core enable until result or timeout, then drains
module custom_axi_ip_seq
   import custom_axi_ip_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [32:0] dout_i,
   input  logic        result_present_i,
   output logic        enable_o,
   output logic        busy_o,
   output logic        result_we_o,
   output logic [31:0] result_o,
   output logic        done_set_o,
   output logic        timeout_set_o
);
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // State and timeout counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SEQ_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: a valid result wins over a timeout expiring in the same cycle
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      result_we_o   = 1'b0;
      done_set_o    = 1'b0;
      timeout_set_o = 1'b0;
      case (state_q)
         SEQ_IDLE: begin
            if (start_i) begin
               state_d = SEQ_RUN;
               cnt_d   = '0;
            end
         end
         SEQ_RUN: begin
            if (result_present_i && dout_i[0]) begin
               result_we_o = 1'b1;
               done_set_o  = 1'b1;
               state_d     = SEQ_DRAIN;
            end else if (cnt_q == CNT_LAST) begin
               timeout_set_o = 1'b1;
               state_d       = SEQ_DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SEQ_DRAIN: begin
            if (!result_present_i) begin
               state_d = SEQ_IDLE;
            end
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   // Enable is decoded from the registered state, so it is glitch-free
   assign enable_o = (state_q == SEQ_RUN);
   assign busy_o   = (state_q != SEQ_IDLE);
   assign result_o = dout_i[32:1];

endmodule

// File: rtl/custom_axi_ip_regs.sv
// rtl/custom_axi_ip_regs.sv - AXI4-Lite register front-end driving the custom_axi_ip core
module custom_axi_ip_regs
   import custom_axi_ip_pkg::*;
#(
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   custom_axi_ip_regs_if.slave  s,
   output logic [31:0]          din_o,
   output logic                 enable_o,
   input  logic [32:0]          dout_i,
   input  logic [1:0]           enable_out_i,
   input  status_e              status_i
);
   // Write holding registers
   logic [1:0]  aw_idx_q;
   logic        aw_full_q;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;
   logic        w_full_q;

   // Response and read-data registers
   logic        bvalid_q;
   axi_resp_e   bresp_q;
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic [31:0] rdata_d;

   // Architectural registers
   logic [31:0] din_q;
   logic [31:0] result_q;
   logic        done_q;
   logic        timeout_q;

   // Sequencer interface
   logic        seq_busy;
   logic        seq_result_we;
   logic [31:0] seq_result;
   logic        seq_done_set;
   logic        seq_timeout_set;

   logic        commit;
   logic        wr_ro;
   logic        start_cmd;
   logic        clr_cmd;
   logic        ar_hs;
   logic [31:0] status_word;
   logic        unused_ok;

   assign s.s_awready = !rst_i && !aw_full_q;
   assign s.s_wready  = !rst_i && !w_full_q;
   assign s.s_arready = !rst_i && !rvalid_q;
   assign s.s_bvalid  = bvalid_q;
   assign s.s_bresp   = bresp_q;
   assign s.s_rvalid  = rvalid_q;
   assign s.s_rdata   = rdata_q;
   assign s.s_rresp   = RESP_OKAY;

   // One write in flight: it commits only once the previous response is taken
   assign commit    = aw_full_q && w_full_q && !bvalid_q;
   assign wr_ro     = is_ro_reg(aw_idx_q);
   assign start_cmd = commit && (aw_idx_q == REG_CTRL) && w_strb_q[0] && w_data_q[CTRL_START_BIT];
   assign clr_cmd   = commit && (aw_idx_q == REG_CTRL) && w_strb_q[0] && w_data_q[CTRL_CLR_BIT];
   assign ar_hs     = s.s_arvalid && s.s_arready;

   // AW and W are captured independently and released together on commit
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         aw_idx_q  <= '0;
         aw_full_q <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         w_full_q  <= 1'b0;
      end else begin
         if (s.s_awvalid && s.s_awready) begin
            aw_idx_q  <= s.s_awaddr[3:2];
            aw_full_q <= 1'b1;
         end else if (commit) begin
            aw_full_q <= 1'b0;
         end
         if (s.s_wvalid && s.s_wready) begin
            w_data_q <= s.s_wdata;
            w_strb_q <= s.s_wstrb;
            w_full_q <= 1'b1;
         end else if (commit) begin
            w_full_q <= 1'b0;
         end
      end
   end

   // Write response: raised the cycle after commit, held until bready
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else if (commit) begin
         bvalid_q <= 1'b1;
         bresp_q  <= wr_ro ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && s.s_bready) begin
         bvalid_q <= 1'b0;
      end
   end

   // DIN with per-byte strobes; changes reach din_o straight away
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         din_q <= '0;
      end else if (commit && (aw_idx_q == REG_DIN)) begin
         for (int b = 0; b < 4; b++) begin
            if (w_strb_q[b]) begin
               din_q[8*b +: 8] <= w_data_q[8*b +: 8];
            end
         end
      end
   end

   // Result capture and sticky flags; a set in the same cycle as CLR wins
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         result_q  <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         if (clr_cmd) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
         end
         if (seq_done_set) begin
            done_q <= 1'b1;
         end
         if (seq_timeout_set) begin
            timeout_q <= 1'b1;
         end
         if (seq_result_we) begin
            result_q <= seq_result;
         end
      end
   end

   assign status_word = {26'd0, status_i, 1'b0, timeout_q, done_q, seq_busy};

   // Read mux over current register values (pre-update on a coincident write)
   always_comb begin
      rdata_d = '0;
      case (s.s_araddr[3:2])
         REG_CTRL:   rdata_d = '0;
         REG_DIN:    rdata_d = din_q;
         REG_RESULT: rdata_d = result_q;
         REG_STATUS: rdata_d = status_word;
         default:    rdata_d = '0;
      endcase
   end

   // Registered read data, held until rready
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rdata_d;
      end else if (rvalid_q && s.s_rready) begin
         rvalid_q <= 1'b0;
      end
   end

   custom_axi_ip_seq #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_seq (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .start_i          (start_cmd),
      .dout_i           (dout_i),
      .result_present_i (enable_out_i[0]),
      .enable_o         (enable_o),
      .busy_o           (seq_busy),
      .result_we_o      (seq_result_we),
      .result_o         (seq_result),
      .done_set_o       (seq_done_set),
      .timeout_set_o    (seq_timeout_set)
   );

   assign din_o     = din_q;
   assign unused_ok = ^{s.s_awaddr[1:0], s.s_araddr[1:0], enable_out_i[1]};

endmodule
